// File: rtl/dual_wb_regfile.sv
`default_nettype none
// ============================================================================
// dual_wb_regfile : 32 x DATA_W register file, two writeback ports, four
//                   bypassed combinational read ports, collision flag and
//                   saturating commit counter.
// Revision        : 1.0
// ============================================================================
module dual_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteEn_inst1_WB,
  input  logic [4:0]        dest_reg_inst1_WB,
  input  logic [DATA_W-1:0] writeData_inst1_WB,
  input  logic              RegWriteEn_inst2_WB,
  input  logic [4:0]        dest_reg_inst2_WB,
  input  logic [DATA_W-1:0] writeData_inst2_WB,
  input  logic [4:0]        rs1_inst1,
  input  logic [4:0]        rs2_inst1,
  input  logic [4:0]        rs1_inst2,
  input  logic [4:0]        rs2_inst2,
  output logic [DATA_W-1:0] rd1_inst1,
  output logic [DATA_W-1:0] rd2_inst1,
  output logic [DATA_W-1:0] rd1_inst2,
  output logic [DATA_W-1:0] rd2_inst2,
  output logic              wb_collision,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [DATA_W-1:0] regs_q [0:31];
  logic              wb_collision_q, wb_collision_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  logic              w_wr1, w_wr2, w_coll;
  logic [CNT_W:0]    w_sum;
  logic [4:0]        w_raddr [0:3];
  logic [DATA_W-1:0] w_rdata [0:3];

  // inst2 is younger, so on a same-register collision inst1's write is dropped
  always_comb begin
    w_wr2          = RegWriteEn_inst2_WB && (dest_reg_inst2_WB != 5'd0);
    w_coll         = w_wr2 && RegWriteEn_inst1_WB &&
                     (dest_reg_inst1_WB == dest_reg_inst2_WB);
    w_wr1          = RegWriteEn_inst1_WB && (dest_reg_inst1_WB != 5'd0) && !w_coll;
    w_sum          = {1'b0, wb_count_q} + {{CNT_W{1'b0}}, w_wr1}
                                        + {{CNT_W{1'b0}}, w_wr2};
    wb_count_d     = w_sum[CNT_W] ? c_cnt_max : w_sum[CNT_W-1:0];
    wb_collision_d = w_coll;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wb_collision_q <= 1'b0;
      wb_count_q     <= '0;
    end else begin
      if (w_wr1) regs_q[dest_reg_inst1_WB] <= writeData_inst1_WB;
      if (w_wr2) regs_q[dest_reg_inst2_WB] <= writeData_inst2_WB;
      wb_collision_q <= wb_collision_d;
      wb_count_q     <= wb_count_d;
    end
  end

  assign w_raddr[0] = rs1_inst1;
  assign w_raddr[1] = rs2_inst1;
  assign w_raddr[2] = rs1_inst2;
  assign w_raddr[3] = rs2_inst2;

  for (genvar g = 0; g < 4; g++) begin : g_rd
    always_comb begin
      w_rdata[g] = regs_q[w_raddr[g]];
      if (reset || (w_raddr[g] == 5'd0))
        w_rdata[g] = '0;
      else if (w_wr2 && (dest_reg_inst2_WB == w_raddr[g]))
        w_rdata[g] = writeData_inst2_WB;
      else if (w_wr1 && (dest_reg_inst1_WB == w_raddr[g]))
        w_rdata[g] = writeData_inst1_WB;
    end
  end

  assign rd1_inst1    = w_rdata[0];
  assign rd2_inst1    = w_rdata[1];
  assign rd1_inst2    = w_rdata[2];
  assign rd2_inst2    = w_rdata[3];
  assign wb_collision = wb_collision_q;
  assign wb_count     = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_wb_regfile.sv
`default_nettype none
// ============================================================================
// tb_dual_wb_regfile : directed bench for dual_wb_regfile (default and
//                      CNT_W=4 instances driven by the same stimulus).
// Revision           : 1.0
// ============================================================================
module tb_dual_wb_regfile;

  logic        clk;
  logic        reset;
  logic        en1, en2;
  logic [4:0]  d1, d2;
  logic [31:0] w1, w2;
  logic [4:0]  ra [0:3];
  logic [31:0] rd [0:3];
  logic [31:0] rds [0:3];
  logic        coll, coll_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int total = 0;
  int bad   = 0;

  dual_wb_regfile dut (
    .clk(clk), .reset(reset),
    .RegWriteEn_inst1_WB(en1), .dest_reg_inst1_WB(d1), .writeData_inst1_WB(w1),
    .RegWriteEn_inst2_WB(en2), .dest_reg_inst2_WB(d2), .writeData_inst2_WB(w2),
    .rs1_inst1(ra[0]), .rs2_inst1(ra[1]), .rs1_inst2(ra[2]), .rs2_inst2(ra[3]),
    .rd1_inst1(rd[0]), .rd2_inst1(rd[1]), .rd1_inst2(rd[2]), .rd2_inst2(rd[3]),
    .wb_collision(coll), .wb_count(cnt)
  );

  dual_wb_regfile #(.DATA_W(32), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .RegWriteEn_inst1_WB(en1), .dest_reg_inst1_WB(d1), .writeData_inst1_WB(w1),
    .RegWriteEn_inst2_WB(en2), .dest_reg_inst2_WB(d2), .writeData_inst2_WB(w2),
    .rs1_inst1(ra[0]), .rs2_inst1(ra[1]), .rs1_inst2(ra[2]), .rs2_inst2(ra[3]),
    .rd1_inst1(rds[0]), .rd2_inst1(rds[1]), .rd1_inst2(rds[2]), .rd2_inst2(rds[3]),
    .wb_collision(coll_s), .wb_count(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en1 = 1'b0; en2 = 1'b0; d1 = 5'd0; d2 = 5'd0; w1 = '0; w2 = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) ra[i] = 5'd0;
    tick(); tick();

    // Reset state, with a would-be bypass held off by reset
    en2 = 1'b1; d2 = 5'd9; w2 = 32'h1234; ra[0] = 5'd9;
    #1;
    chk("reset_bypass_rd1_inst1", rd[0], 32'h0);
    chk("reset_count", {16'h0, cnt}, 32'd0);
    chk("reset_coll", {31'h0, coll}, 32'd0);
    tick();
    chk("reset_write_blocked_count", {16'h0, cnt}, 32'd0);

    // Dual write x5/x6
    reset = 1'b0; idle();
    en1 = 1'b1; d1 = 5'd5; w1 = 32'h11;
    en2 = 1'b1; d2 = 5'd6; w2 = 32'h22;
    ra[0] = 5'd5; ra[3] = 5'd6;
    #1;
    chk("dual_bypass_x5", rd[0], 32'h11);
    chk("dual_bypass_x6", rd[3], 32'h22);
    tick(); idle();
    chk("dual_x5", rd[0], 32'h11);
    chk("dual_x6", rd[3], 32'h22);
    chk("dual_count", {16'h0, cnt}, 32'd2);
    chk("dual_coll", {31'h0, coll}, 32'd0);

    // Collision on x7
    en1 = 1'b1; en2 = 1'b1; d1 = 5'd7; d2 = 5'd7; w1 = 32'hAAAA; w2 = 32'hBBBB;
    ra[2] = 5'd7;
    #1;
    chk("coll_bypass_x7", rd[2], 32'hBBBB);
    tick(); idle();
    chk("coll_x7", rd[2], 32'hBBBB);
    chk("coll_flag", {31'h0, coll}, 32'd1);
    chk("coll_count", {16'h0, cnt}, 32'd3);
    tick();
    chk("coll_flag_clears", {31'h0, coll}, 32'd0);
    chk("coll_count_idle", {16'h0, cnt}, 32'd3);

    // Same-cycle bypass from both ports into different readers
    en2 = 1'b1; d2 = 5'd9;  w2 = 32'h1234;
    en1 = 1'b1; d1 = 5'd10; w1 = 32'hCAFE;
    ra[0] = 5'd9; ra[1] = 5'd10;
    #1;
    chk("bypass_inst2_x9", rd[0], 32'h1234);
    chk("bypass_inst1_x10", rd[1], 32'hCAFE);
    tick(); idle();
    chk("stored_x9", rd[0], 32'h1234);
    chk("stored_x10", rd[1], 32'hCAFE);
    chk("bypass_count", {16'h0, cnt}, 32'd5);

    // x0 protection
    en1 = 1'b1; en2 = 1'b1; d1 = 5'd0; d2 = 5'd0; w1 = 32'hFFFF_FFFF; w2 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) ra[i] = 5'd0;
    #1;
    chk("x0_bypass_rd1_inst1", rd[0], 32'h0);
    chk("x0_bypass_rd2_inst2", rd[3], 32'h0);
    tick(); idle();
    chk("x0_rd1_inst1", rd[0], 32'h0);
    chk("x0_rd2_inst1", rd[1], 32'h0);
    chk("x0_rd1_inst2", rd[2], 32'h0);
    chk("x0_rd2_inst2", rd[3], 32'h0);
    chk("x0_count", {16'h0, cnt}, 32'd5);
    chk("x0_coll", {31'h0, coll}, 32'd0);

    // Same destination with inst2 disabled: no collision, inst1 commits
    en1 = 1'b1; d1 = 5'd11; w1 = 32'h77; d2 = 5'd11; w2 = 32'h88;
    ra[0] = 5'd11;
    tick(); idle();
    chk("halfcoll_coll", {31'h0, coll}, 32'd0);
    chk("halfcoll_x11", rd[0], 32'h77);
    chk("halfcoll_count", {16'h0, cnt}, 32'd6);

    // Saturation on the CNT_W=4 instance: 6 -> 14 -> 15 -> 15
    for (int i = 0; i < 4; i++) begin
      en1 = 1'b1; d1 = 5'd12; w1 = i;
      en2 = 1'b1; d2 = 5'd13; w2 = i + 100;
      tick();
    end
    idle();
    chk("sat_preload", {28'h0, cnt_s}, 32'd14);
    en1 = 1'b1; d1 = 5'd12; w1 = 32'h1;
    en2 = 1'b1; d2 = 5'd13; w2 = 32'h2;
    tick();
    chk("sat_reach_max", {28'h0, cnt_s}, 32'd15);
    chk("wide_no_sat", {16'h0, cnt}, 32'd16);
    tick(); idle();
    chk("sat_hold_max", {28'h0, cnt_s}, 32'd15);
    chk("wide_count_18", {16'h0, cnt}, 32'd18);

    // Reset mid-operation
    en1 = 1'b1; d1 = 5'd3; w1 = 32'h55; ra[0] = 5'd3; ra[1] = 5'd13;
    tick(); idle();
    chk("pre_reset_x3", rd[0], 32'h55);
    chk("pre_reset_count", {16'h0, cnt}, 32'd19);
    reset = 1'b1; en1 = 1'b1; d1 = 5'd3; w1 = 32'h66;
    #1;
    chk("in_reset_bypass_x3", rd[0], 32'h0);
    chk("in_reset_x13", rd[1], 32'h0);
    tick();
    chk("after_reset_x3", rd[0], 32'h0);
    chk("after_reset_count", {16'h0, cnt}, 32'd0);
    chk("after_reset_count_s", {28'h0, cnt_s}, 32'd0);
    chk("after_reset_coll", {31'h0, coll}, 32'd0);
    reset = 1'b0; idle();
    #1;
    chk("released_x3", rd[0], 32'h0);
    chk("released_x13", rd[1], 32'h0);
    en1 = 1'b1; d1 = 5'd3; w1 = 32'h66;
    tick(); idle();
    chk("resume_x3", rd[0], 32'h66);
    chk("resume_count", {16'h0, cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dual_wb_regfile.md
DUAL_WB_REGFILE -- requirements
Module: dual_wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the writeback counter width.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port RegWriteEn_inst1_WB  input  1  meaning the inst1 writeback enable.
REQ-006 The block SHALL have port dest_reg_inst1_WB  input  5  meaning the inst1 destination register.
REQ-007 The block SHALL have port writeData_inst1_WB  input  DATA_W  meaning the inst1 writeback data.
REQ-008 The block SHALL have port RegWriteEn_inst2_WB  input  1  meaning the inst2 writeback enable.
REQ-009 The block SHALL have port dest_reg_inst2_WB  input  5  meaning the inst2 destination register.
REQ-010 The block SHALL have port writeData_inst2_WB  input  DATA_W  meaning the inst2 writeback data.
REQ-011 The block SHALL have ports rs1_inst1, rs2_inst1, rs1_inst2, rs2_inst2  input  5 each  meaning the four read addresses.
REQ-012 The block SHALL have ports rd1_inst1, rd2_inst1, rd1_inst2, rd2_inst2  output  DATA_W each  meaning the four read data outputs.
REQ-013 The block SHALL have port wb_collision  output  1  meaning a registered flag marking a same-destination dual write.
REQ-014 The block SHALL have port wb_count  output  CNT_W  meaning a saturating count of committed register writes.

Function
REQ-015 The block SHALL hold 32 registers of DATA_W bits, x1..x31 writable; x0 SHALL never be written.
REQ-016 On a rising edge with reset low, RegWriteEn_inst1_WB=1 and dest_reg_inst1_WB!=0, the block SHALL write writeData_inst1_WB to that register.
REQ-017 The same rule SHALL apply independently to inst2, so two different registers can be written in one cycle.
REQ-018 If both enables are 1 and both destinations are equal and nonzero, only writeData_inst2_WB SHALL be written, because inst2 is the younger instruction.
REQ-019 Reads SHALL be combinational, with zero-cycle latency.
REQ-020 A read of address 0 SHALL return 0.
REQ-021 A read address matching an active nonzero write in the same cycle SHALL return the write data (write-through bypass), with inst2 taking priority over inst1.
REQ-022 A read address matching no active write SHALL return the stored array value.
REQ-023 All four read ports SHALL be independent; any combination of equal addresses SHALL be legal.
REQ-024 wb_collision SHALL be 1 in the cycle after an edge at which the REQ-018 condition held, and 0 otherwise.
REQ-025 A collision on x0, or one where either enable is 0, SHALL NOT set wb_collision.
REQ-026 wb_count SHALL increase at each edge by the number of writes committed to nonzero registers at that edge: 0, 1, or 2.
REQ-027 A collision SHALL count as 1 write.
REQ-028 wb_count SHALL saturate at 2^CNT_W-1; an increment of 2 from 2^CNT_W-2 SHALL yield 2^CNT_W-1, with no wrap-around.

Reset
REQ-029 When reset is high at a rising edge, all 31 writable registers SHALL become 0, wb_collision SHALL become 0, and wb_count SHALL become 0.
REQ-030 Reset SHALL take priority over any write enables asserted in the same cycle, and no write or count SHALL occur.
REQ-031 While reset is high, all four read outputs SHALL be 0, including any bypass.
REQ-032 Operation SHALL resume normally at the first edge with reset low.
REQ-033 Deassertion of reset mid-sequence SHALL require no idle cycles.

Verification
REQ-034 Dual write: inst1 writes x5=0x11, inst2 writes x6=0x22 -> the next cycle rd1_inst1(x5)=0x11, rd2_inst2(x6)=0x22, wb_count=2, wb_collision=0.
REQ-035 Collision: both enables set, dest=7, data1=0xAAAA, data2=0xBBBB -> x7=0xBBBB, wb_collision=1 for one cycle, wb_count increments by 1.
REQ-036 Bypass: inst2 writes x9=0x1234 while rs1_inst1=9 -> rd1_inst1=0x1234 in the same cycle, before the edge.
REQ-037 x0 protection: inst1 and inst2 both write x0=0xFFFF_FFFF -> all reads of x0 return 0, wb_count is unchanged, wb_collision=0.
REQ-038 Saturation: with CNT_W=4 and the count preloaded to 14 through writes, one dual write -> wb_count=15; a further dual write -> wb_count stays 15.
REQ-039 Reset mid-operation: x3=0x55 is stored, then reset is asserted together with an inst1 write x3=0x66 -> after the edge x3=0, wb_count=0, and all reads are 0 while reset is held.
